// File: rtl/instr_fetch_pkg.sv
// ----------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared ops header for the fetch/decode pair.
//   - Opcode constants (upper nibble of the 16-bit instruction word).
//   - Instruction word width.
//   - Fetch FSM state encodings, also exported on the fetch debug port.
// ----------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam int INSTR_W = 16;

  // Control-flow opcodes, kept here so fetch and decode agree on them.
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_BEQ  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_REQ   = 3'd1,
    FS_READY = 3'd2,
    FS_ISSUE = 3'd3,
    FS_HALT  = 3'd4
  } fetch_state_e;

  // True for words that change the flow of control.
  function automatic logic is_flow_op(input logic [INSTR_W-1:0] word);
    logic [3:0] op;
    op = word[INSTR_W-1 -: 4];
    return (op == OP_JMP) || (op == OP_BEQ) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//   Holds the program counter, fetches one 16-bit word per memory transaction
//   and hands it to the decoder with a one-cycle decode-enable pulse.
//
//   Memory handshake: O_mem_req/O_mem_addr are held stable while in REQ until
//   the cycle I_mem_ready is high; I_mem_data is valid in that same cycle and
//   is captured on the rising edge that ends it. A branch may drop O_mem_req
//   before ready arrives; the abandoned request must be tolerated by memory.
//
//   Ports
//     I_clk, I_reset          clock, async active-high reset
//     I_stall                 decoder cannot take a word this cycle
//     I_branch_en/_target     one-cycle redirect request and new PC
//     O_mem_req/O_mem_addr    memory read request and word address
//     I_mem_ready/I_mem_data  read data valid (same cycle) and word
//     O_instruction, O_pc     latched word and its address
//     O_dec_enable            decode-enable pulse
//     O_fault                 sticky fetch fault
//     O_dbg_state             current FSM state
//
//   Build option: IFETCH_TIMEOUT_EN adds a memory wait timeout that sets
//   O_fault and parks the FSM in HALT until reset. Without it REQ waits
//   forever and O_fault is constant 0.
// ----------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic               I_stall,
  input  logic               I_branch_en,
  input  logic [ADDR_W-1:0]  I_branch_target,
  output logic               O_mem_req,
  output logic [ADDR_W-1:0]  O_mem_addr,
  input  logic               I_mem_ready,
  input  logic [INSTR_W-1:0] I_mem_data,
  output logic [INSTR_W-1:0] O_instruction,
  output logic               O_dec_enable,
  output logic [ADDR_W-1:0]  O_pc,
  output logic               O_fault,
  output fetch_state_e       O_dbg_state
);

  fetch_state_e       state;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               mem_req_q;
  logic               dec_en_q;
  logic               timeout_hit;

`ifdef IFETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             fault_q;

  // Fires on the last allowed REQ cycle; a branch in that cycle wins.
  assign timeout_hit = (state == FS_REQ) && !I_mem_ready && !I_branch_en &&
                       (wait_cnt == CNT_LAST);

  // Counter is zero whenever REQ is (re)entered: it is cleared outside REQ,
  // on ready, and on a redirect that restarts the request.
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      if (state != FS_REQ || I_mem_ready || I_branch_en) wait_cnt <= '0;
      else                                               wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit) fault_q <= 1'b1;
    end
  end

  assign O_fault = fault_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
  assign O_fault        = 1'b0;
`endif

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state     <= FS_IDLE;
      pc        <= RESET_PC;
      instr_q   <= '0;
      pc_q      <= RESET_PC;
      mem_req_q <= 1'b0;
      dec_en_q  <= 1'b0;
    end else begin
      mem_req_q <= 1'b0;
      dec_en_q  <= 1'b0;
      case (state)
        FS_IDLE: begin
          state     <= FS_REQ;
          mem_req_q <= 1'b1;
          if (I_branch_en) pc <= I_branch_target;
        end
        FS_REQ: begin
          if (I_branch_en) begin
            // Redirect beats a same-cycle ready: data dropped, PC not bumped.
            pc        <= I_branch_target;
            mem_req_q <= 1'b1;
          end else if (I_mem_ready) begin
            instr_q <= I_mem_data;
            pc_q    <= pc;
            pc      <= pc + 1'b1;
            state   <= FS_READY;
          end else if (timeout_hit) begin
            state <= FS_HALT;
          end else begin
            mem_req_q <= 1'b1;
          end
        end
        FS_READY: begin
          if (I_branch_en) begin
            // Held word is discarded; O_instruction keeps it but never issues.
            pc        <= I_branch_target;
            state     <= FS_REQ;
            mem_req_q <= 1'b1;
          end else if (!I_stall) begin
            state    <= FS_ISSUE;
            dec_en_q <= 1'b1;
          end
        end
        FS_ISSUE: begin
          // The pulse for this word is already out; a redirect only steers
          // the next fetch.
          state     <= FS_REQ;
          mem_req_q <= 1'b1;
          if (I_branch_en) pc <= I_branch_target;
        end
        FS_HALT: begin
          state <= FS_HALT;
        end
        default: begin
          state <= FS_IDLE;
        end
      endcase
    end
  end

  assign O_mem_req     = mem_req_q;
  assign O_mem_addr    = pc;
  assign O_instruction = instr_q;
  assign O_dec_enable  = dec_en_q;
  assign O_pc          = pc_q;
  assign O_dbg_state   = state;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Upstream neighbour of the instruction decoder.
- Holds the program counter and fetches one 16-bit instruction word per transaction over a req/ready memory port.
- Presents each word to the decoder with a one-cycle decode-enable pulse.
- Accepts branch redirects and downstream stall from the control path.

Parameters:
- ADDR_W, 8, program-counter / memory address width (matches the 8-bit immediate and jump target).
- RESET_PC, 0, PC value loaded on reset.
- TIMEOUT, 15, memory-wait cycles before fault; used only with IFETCH_TIMEOUT_EN.

Ports:
- I_clk  in  1  clock; all state changes on its rising edge.
- I_reset  in  1  asynchronous, active-high reset.
- I_stall  in  1  downstream cannot accept an instruction this cycle.
- I_branch_en  in  1  redirect request (one-cycle pulse).
- I_branch_target  in  ADDR_W  new PC for the redirect.
- O_mem_req  out  1  memory read request.
- O_mem_addr  out  ADDR_W  word address of the request.
- I_mem_ready  in  1  memory data valid, same cycle.
- I_mem_data  in  16  instruction word.
- O_instruction  out  16  latched instruction for the decoder.
- O_dec_enable  out  1  decoder enable pulse.
- O_pc  out  ADDR_W  address of the word in O_instruction.
- O_fault  out  1  sticky fetch fault.

Behaviour:
- Reset (async, immediate, any state):
  - state = IDLE, PC = RESET_PC.
  - O_mem_req = 0, O_mem_addr = RESET_PC, O_instruction = 16'h0000, O_dec_enable = 0, O_pc = RESET_PC, O_fault = 0.
- All outputs are registered or decoded from the registered state only; there is no combinational path from inputs to outputs.
- States: IDLE, REQ, READY, ISSUE, HALT.
- IDLE: go to REQ next cycle.
- REQ:
  - O_mem_req = 1, O_mem_addr = PC, held stable until I_mem_ready.
  - On I_mem_ready: latch I_mem_data into O_instruction, set O_pc = PC, set PC = PC+1, go to READY.
- READY: if !I_stall go to ISSUE; otherwise hold, with O_instruction and O_pc stable.
- ISSUE:
  - O_dec_enable = 1 for exactly this cycle.
  - Go to REQ next cycle.
  - Stall is not sampled in ISSUE.
- Throughput: zero-wait memory gives 1 instruction per 3 cycles (REQ, READY, ISSUE). Each memory wait cycle adds 1.
- Branch (I_branch_en = 1 in IDLE/REQ/READY/ISSUE):
  - Highest priority.
  - PC = I_branch_target; go to REQ next cycle.
  - Any word latched this cycle or held in READY is discarded and never issued.
  - If the branch arrives in ISSUE, the current O_dec_enable pulse still completes; the next fetch uses the target.
  - O_mem_req may drop mid-transaction; memory must tolerate an abandoned request.
  - Branch concurrent with I_mem_ready in REQ: data is dropped, the redirect wins, and PC is not incremented.
- Branch in HALT is ignored.
- PC wrap: 2^ADDR_W-1 + 1 = 0, with no flag.
- I_stall while in REQ has no effect; the fetch completes and waits in READY.

Optional Feature:
- Macro IFETCH_TIMEOUT_EN.
- Defined:
  - A wait counter runs in REQ and clears on entry to REQ and on I_mem_ready.
  - When it reaches TIMEOUT with no ready: set O_fault = 1 (sticky), drop O_mem_req, enter HALT.
  - HALT is left only by reset.
- Undefined:
  - No counter, HALT unreachable, O_fault tied 0.
  - REQ waits indefinitely.

Decomposition:
- Shared ops header (existing): opcode constants. Add the fetch state encodings and the instruction width (16) there.
- A single module is sufficient; no sub-module is needed.

Test Plan:
- Reset, zero-wait memory, mem[0..2] = 16'h1234, 16'h5678, 16'h9ABC -> O_dec_enable pulses on cycles 3, 6, 9 after reset release, with O_instruction/O_pc = 1234/0, 5678/1, 9ABC/2.
- Memory ready delayed 2 cycles at addr 0 -> O_mem_req and O_mem_addr = 0 held 3 cycles; first pulse at cycle 5.
- I_stall high 4 cycles while in READY -> no pulse and O_instruction stable; pulse 1 cycle after stall drops.
- I_branch_en with target 8'h40, coincident with I_mem_ready at addr 5 -> word at 5 never issued; next O_mem_addr = 0x40; next issued O_pc = 0x40.
- PC = 8'hFF fetch -> next O_mem_addr = 8'h00.
- With IFETCH_TIMEOUT_EN, ready never asserted -> O_fault = 1 after 15 REQ cycles, O_mem_req = 0, no further pulses; I_reset clears O_fault.
